uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, DBIT data bits, SB_TICK-tick stop bit.
// Reports each completed frame with a one-cycle rx_done_tick plus dout and frame_err.
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err
);

  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [3:0]    SMid  = 4'd7;
  localparam logic [3:0]    SBit  = 4'd15;
  localparam logic [3:0]    SStop = 4'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic            sync_q, rx_s_q;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] b_shift;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;

  // LSB arrives first, so each new bit enters at the MSB and slides down.
  if (DBIT > 1) begin : g_shift
    assign b_shift = {rx_s_q, b_q[DBIT-1:1]};
  end else begin : g_shift1
    assign b_shift = rx_s_q;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          s_d     = 4'd0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == SMid) begin
            // Line must still be low mid start bit, otherwise treat it as a glitch.
            if (!rx_s_q) begin
              state_d = StData;
              s_d     = 4'd0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == SBit) begin
            s_d = 4'd0;
            b_d = b_shift;
            if (n_q == NLast) begin
              state_d = StStop;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == SStop) begin
            state_d = StIdle;
            dout_d  = b_q;
            ferr_d  = ~rx_s_q;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= StIdle;
      s_q     <= 4'd0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= rx;
      rx_s_q  <= sync_q;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against
// a frame-level reference queue of expected {frame_err, data} results.
module tb_uart_rx;

  localparam int unsigned DBIT   = 8;
  localparam int unsigned BITCLK = 64;  // 16 s_tick per bit, s_tick every 4 clk

  logic            clk;
  logic            reset_n;
  logic            rx;
  logic            s_tick;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            frame_err;

  int passed;
  int total;
  int dbl_cnt;
  logic prev_done;
  logic tick_en;
  int unsigned tick_ph;
  logic [DBIT:0] got_q[$];
  logic [DBIT:0] exp_q[$];

  uart_rx #(
    .DBIT   (DBIT),
    .SB_TICK(16)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .s_tick      (s_tick),
    .rx_done_tick(rx_done_tick),
    .dout        (dout),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    s_tick  = 1'b0;
    tick_ph = 0;
    forever begin
      @(negedge clk);
      tick_ph = tick_ph + 1;
      s_tick  = tick_en && ((tick_ph % 4) == 0);
    end
  end

  // Observed frames, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      got_q.push_back({frame_err, dout});
      if (prev_done === 1'b1) dbl_cnt <= dbl_cnt + 1;
    end
    prev_done <= rx_done_tick;
  end

  task automatic idle_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // pause_clk > 0 freezes s_tick mid-bit while the line holds its level.
  task automatic send_bit(input logic v, input int pause_clk);
    rx = v;
    idle_clk(BITCLK / 2);
    if (pause_clk > 0) begin
      tick_en = 1'b0;
      idle_clk(pause_clk);
      tick_en = 1'b1;
    end
    idle_clk(BITCLK / 2);
  endtask

  // Bad stop bits are held low only past the stop sample point, then the line idles.
  task automatic send_frame(input logic [DBIT-1:0] data, input logic stop, input int pause_bit);
    send_bit(1'b0, 0);
    for (int i = 0; i < DBIT; i++) send_bit(data[i], (i == pause_bit) ? 100 : 0);
    if (stop) begin
      send_bit(1'b1, 0);
    end else begin
      rx = 1'b0;
      idle_clk(48);
      rx = 1'b1;
      idle_clk(16);
      idle_clk(BITCLK);
    end
  endtask

  task automatic wait_frames(input int k);
    for (int i = 0; i < 400 && got_q.size() < k; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    idle_clk(5);
    total++;
    if ({rx_done_tick, frame_err, dout} !== {1'b0, 1'b0, 8'h00})
      $display("FAIL reset_outputs: got done=%b ferr=%b dout=%h, need 0 0 00",
               rx_done_tick, frame_err, dout);
    else passed++;
    reset_n = 1'b1;
    idle_clk(BITCLK);
    total++;
    if (got_q.size() !== 0) $display("FAIL reset_idle_pulse: got %0d pulses, need 0", got_q.size());
    else passed++;
  endtask

  task automatic test_basic;
    got_q.delete();
    send_frame(8'hA5, 1'b1, -1);
    wait_frames(1);
    idle_clk(BITCLK);
    total++;
    if (got_q.size() !== 1) $display("FAIL basic_count: got %0d pulses, need 1", got_q.size());
    else passed++;
    total++;
    if ({frame_err, dout} !== {1'b0, 8'hA5})
      $display("FAIL basic_data: got ferr=%b dout=%h, need 0 a5", frame_err, dout);
    else passed++;
  endtask

  task automatic test_glitch;
    got_q.delete();
    rx = 1'b0;
    idle_clk(16);
    rx = 1'b1;
    idle_clk(3 * BITCLK);
    total++;
    if (got_q.size() !== 0) $display("FAIL glitch_pulse: got %0d pulses, need 0", got_q.size());
    else passed++;
    total++;
    if ({frame_err, dout} !== {1'b0, 8'hA5})
      $display("FAIL glitch_hold: got ferr=%b dout=%h, need 0 a5", frame_err, dout);
    else passed++;
  endtask

  task automatic test_frame_err;
    got_q.delete();
    send_frame(8'h3C, 1'b0, -1);
    idle_clk(2 * BITCLK);
    total++;
    if (got_q.size() !== 1) $display("FAIL ferr_count: got %0d pulses, need 1", got_q.size());
    else passed++;
    total++;
    if ({frame_err, dout} !== {1'b1, 8'h3C})
      $display("FAIL ferr_data: got ferr=%b dout=%h, need 1 3c", frame_err, dout);
    else passed++;
  endtask

  task automatic test_back_to_back;
    got_q.delete();
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    wait_frames(2);
    idle_clk(BITCLK);
    total++;
    if (got_q.size() !== 2) begin
      $display("FAIL b2b_count: got %0d pulses, need 2", got_q.size());
    end else begin
      passed++;
      total++;
      if (got_q[0] !== {1'b0, 8'h00}) $display("FAIL b2b_first: got %h, need 000", got_q[0]);
      else passed++;
      total++;
      if (got_q[1] !== {1'b0, 8'hFF}) $display("FAIL b2b_second: got %h, need 0ff", got_q[1]);
      else passed++;
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] d;
    d = 8'h5A;
    got_q.delete();
    send_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(d[i], 0);
    rx = d[3];
    idle_clk(BITCLK / 2);
    reset_n = 1'b0;
    idle_clk(4);
    total++;
    if ({frame_err, dout} !== 9'h000)
      $display("FAIL midrst_clear: got ferr=%b dout=%h, need 0 00", frame_err, dout);
    else passed++;
    reset_n = 1'b1;
    rx = 1'b1;
    idle_clk(6 * BITCLK);
    total++;
    if (got_q.size() !== 0) $display("FAIL midrst_abort: got %0d pulses, need 0", got_q.size());
    else passed++;
    send_frame(8'h81, 1'b1, -1);
    wait_frames(1);
    idle_clk(BITCLK);
    total++;
    if (got_q.size() !== 1 || got_q[0] !== {1'b0, 8'h81})
      $display("FAIL midrst_next: got %0d pulses dout=%h, need 1 pulse 81", got_q.size(), dout);
    else passed++;
  endtask

  task automatic test_pause;
    got_q.delete();
    send_frame(8'hC6, 1'b1, 4);
    wait_frames(1);
    idle_clk(BITCLK);
    total++;
    if (got_q.size() !== 1 || {frame_err, dout} !== {1'b0, 8'hC6})
      $display("FAIL pause_data: got %0d pulses ferr=%b dout=%h, need 1 0 c6",
               got_q.size(), frame_err, dout);
    else passed++;
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic       stop;
    got_q.delete();
    exp_q.delete();
    for (int f = 0; f < 10; f++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      exp_q.push_back({~stop, d});
      send_frame(d, stop, -1);
      idle_clk(BITCLK * $urandom_range(0, 2));
    end
    wait_frames(exp_q.size());
    idle_clk(BITCLK);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL rand_count: got %0d frames, need %0d", got_q.size(), exp_q.size());
    end else begin
      passed++;
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i])
          $display("FAIL rand_frame%0d: got %h, need %h", i, got_q[i], exp_q[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_pulse_width;
    total++;
    if (dbl_cnt !== 0) $display("FAIL pulse_width: got %0d double-wide pulses, need 0", dbl_cnt);
    else passed++;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    dbl_cnt   = 0;
    prev_done = 1'b0;
    tick_en   = 1'b1;
    rx        = 1'b1;
    reset_n   = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_mid_reset();
    test_pause();
    test_random();
    test_pulse_width();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
